// File: rtl/merge_pkg.sv
// Shared constants and FSM encoding for the merge tree front-end.
package merge_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam logic [DATA_WIDTH_DEF-1:0] SENTINEL = {DATA_WIDTH_DEF{1'b1}};

  // One-hot feeder states
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    START = 3'b010,
    FEED  = 3'b100
  } feed_state_t;

endpackage

// File: rtl/dist_ram_dp.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
module dist_ram_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/merge_run_feeder.sv
// Double-buffers sorted (A,B) run pairs in ping-pong banks and streams their heads
// into the first serial merge node, padding exhausted runs with an all-ones sentinel.
module merge_run_feeder
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RUN_LEN    = 8,
  parameter int ADDR_W     = $clog2(RUN_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  merge_sel,
  output logic [DATA_WIDTH-1:0] feed_A,
  output logic [DATA_WIDTH-1:0] feed_B,
  output logic                  start_merge,
  output logic                  feeding,
  output logic                  pair_done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(2*RUN_LEN-1);
  localparam logic [CNT_W-1:0] RUN_END   = CNT_W'(RUN_LEN);

  feed_state_t state;

  logic             rst_q;
  logic [1:0]       bank_full;
  logic             wbank;
  logic             rbank;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] fcnt;
  logic [CNT_W-1:0] ptr_a;
  logic [CNT_W-1:0] ptr_b;

  logic                  load_fire;
  logic                  load_last;
  logic                  feed_last;
  logic                  a_done;
  logic                  b_done;
  logic                  take_b;
  logic                  we_a;
  logic                  we_b;
  logic [CNT_W-1:0]      waddr;
  logic [CNT_W-1:0]      raddr_a;
  logic [CNT_W-1:0]      raddr_b;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  // Holding in_ready low through reset and the cycle after keeps the load side quiet
  // until every flag and counter has settled.
  assign in_ready  = !rst && !rst_q && !bank_full[wbank];
  assign load_fire = in_valid && in_ready;
  assign load_last = load_fire && (wcnt == LAST_WORD);
  assign feed_last = (state == FEED) && (fcnt == LAST_WORD);

  assign waddr = {wbank, wcnt[ADDR_W-1:0]};
  assign we_a  = load_fire && !wcnt[ADDR_W];
  assign we_b  = load_fire &&  wcnt[ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q     <= 1'b1;
      wcnt      <= '0;
      wbank     <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      rst_q <= 1'b0;
      if (load_fire) wcnt <= wcnt + CNT_W'(1);
      if (load_last) begin
        wbank            <= ~wbank;
        bank_full[wbank] <= 1'b1;
      end
      // Loading only targets an empty bank and feeding only drains a full one,
      // so these two updates always land on different bits.
      if (feed_last) bank_full[rbank] <= 1'b0;
    end
  end

  assign a_done = (ptr_a == RUN_END);
  assign b_done = (ptr_b == RUN_END);
  // A sentinel tie can point the node at an exhausted side; drain the other one then.
  assign take_b = merge_sel ? !b_done : a_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rbank       <= 1'b0;
      ptr_a       <= '0;
      ptr_b       <= '0;
      fcnt        <= '0;
      start_merge <= 1'b0;
      feeding     <= 1'b0;
      pair_done   <= 1'b0;
    end else begin
      start_merge <= 1'b0;
      pair_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bank_full[rbank]) begin
            state       <= START;
            start_merge <= 1'b1;
          end
        end
        START: begin
          ptr_a   <= '0;
          ptr_b   <= '0;
          fcnt    <= '0;
          state   <= FEED;
          feeding <= 1'b1;
        end
        FEED: begin
          fcnt <= fcnt + CNT_W'(1);
          if (take_b) begin
            if (!b_done) ptr_b <= ptr_b + CNT_W'(1);
          end else if (!a_done) begin
            ptr_a <= ptr_a + CNT_W'(1);
          end
          if (fcnt == LAST_WORD) begin
            rbank     <= ~rbank;
            pair_done <= 1'b1;
            feeding   <= 1'b0;
            if (bank_full[~rbank]) begin
              state       <= START;
              start_merge <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          feeding <= 1'b0;
        end
      endcase
    end
  end

  assign raddr_a = {rbank, ptr_a[ADDR_W-1:0]};
  assign raddr_b = {rbank, ptr_b[ADDR_W-1:0]};

  dist_ram_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (CNT_W)
  ) u_store_a (
    .clk   (clk),
    .we    (we_a),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (raddr_a),
    .rdata (rd_a)
  );

  dist_ram_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (CNT_W)
  ) u_store_b (
    .clk   (clk),
    .we    (we_b),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (raddr_b),
    .rdata (rd_b)
  );

  // Heads read combinationally from the registered pointers; forced to 0 outside FEED.
  assign feed_A = !feeding ? '0 : (a_done ? {DATA_WIDTH{1'b1}} : rd_a);
  assign feed_B = !feeding ? '0 : (b_done ? {DATA_WIDTH{1'b1}} : rd_b);

endmodule

// File: tb/tb_merge_run_feeder.sv
// Directed bench for merge_run_feeder with RUN_LEN=4; the merge node is modelled as A>B.
module tb_merge_run_feeder;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        merge_sel;
  logic [31:0] feed_A;
  logic [31:0] feed_B;
  logic        start_merge;
  logic        feeding;
  logic        pair_done;

  merge_run_feeder #(
    .DATA_WIDTH (32),
    .RUN_LEN    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .merge_sel   (merge_sel),
    .feed_A      (feed_A),
    .feed_B      (feed_B),
    .start_merge (start_merge),
    .feeding     (feeding),
    .pair_done   (pair_done)
  );

  assign merge_sel = (feed_A > feed_B);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks_total;
  int          checks_passed;
  int          cycle;
  int          ready_low;
  bit          bp;
  logic [31:0] load_q [$];
  logic [31:0] cons_q [$];
  logic [31:0] fa_q [$];
  logic [31:0] fb_q [$];
  int          start_cyc [$];
  int          done_cyc [$];
  logic [31:0] exp8 [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks_total++;
    assert (obs === expv) checks_passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // One clock: drive load inputs, sample mid-cycle, then advance past the edge.
  task automatic tick();
    logic        rdy, fe, sm, pd, sel;
    logic [31:0] fa, fb;
    if (load_q.size() > 0) begin
      in_data  = load_q[0];
      in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end else begin
      in_data  = '0;
      in_valid = 1'b0;
    end
    @(negedge clk);
    rdy = in_ready; fe = feeding; sm = start_merge; pd = pair_done;
    sel = merge_sel; fa = feed_A; fb = feed_B;
    @(posedge clk);
    #1;
    cycle++;
    if (in_valid && rdy) void'(load_q.pop_front());
    if (!rdy && load_q.size() > 0) ready_low++;
    if (fe) begin
      cons_q.push_back(sel ? fb : fa);
      fa_q.push_back(fa);
      fb_q.push_back(fb);
    end
    if (sm) start_cyc.push_back(cycle);
    if (pd) done_cyc.push_back(cycle);
  endtask

  task automatic clear_obs();
    cons_q.delete(); fa_q.delete(); fb_q.delete();
    start_cyc.delete(); done_cyc.delete();
    ready_low = 0;
  endtask

  task automatic push8(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
    load_q.push_back(w0); load_q.push_back(w1); load_q.push_back(w2); load_q.push_back(w3);
    load_q.push_back(w4); load_q.push_back(w5); load_q.push_back(w6); load_q.push_back(w7);
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k = 0;
    while (done_cyc.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_dones"}, 32'(done_cyc.size()), 32'(n));
  endtask

  task automatic check_pair(input string tag, input int base);
    check({tag, "_len"}, 32'(cons_q.size() >= base + 8), 32'd1);
    if (cons_q.size() >= base + 8) begin
      for (int i = 0; i < 8; i++)
        check($sformatf("%s_w%0d", tag, i), cons_q[base+i], exp8[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_feed_A", feed_A, 32'd0);
    check("rst_feed_B", feed_B, 32'd0);
    check("rst_start", 32'(start_merge), 32'd0);
    check("rst_feeding", 32'(feeding), 32'd0);
    check("rst_done", 32'(pair_done), 32'd0);
    rst = 1'b0;
    clear_obs();
  endtask

  initial begin
    checks_total = 0; checks_passed = 0; cycle = 0; ready_low = 0; bp = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Interleaved runs
    push8(1, 3, 5, 7, 2, 4, 6, 8);
    run_until(1, 60, "t1");
    exp8 = '{1, 2, 3, 4, 5, 6, 7, 8};
    check_pair("t1", 0);
    check("t1_starts", 32'(start_cyc.size()), 32'd1);
    check("t1_feed_cycles", 32'(fa_q.size()), 32'd8);
    if (start_cyc.size() == 1 && done_cyc.size() == 1)
      check("t1_start_to_done", 32'(done_cyc[0] - start_cyc[0]), 32'd9);
    check("t1_ready_low", 32'(ready_low), 32'd1);
    check("t1_ready_after", 32'(in_ready), 32'd1);

    // One-sided: A drains first, B then walks alone
    clear_obs();
    push8(1, 2, 3, 4, 5, 6, 7, 8);
    run_until(1, 60, "t2");
    check_pair("t2", 0);
    if (fa_q.size() == 8) begin
      check("t2_fa3", fa_q[3], 32'd4);
      check("t2_fa4_sentinel", fa_q[4], 32'hFFFF_FFFF);
      check("t2_fb4", fb_q[4], 32'd5);
      check("t2_fb7", fb_q[7], 32'd8);
    end

    // Real all-ones key ties with the sentinel on the final cycle
    clear_obs();
    push8(1, 2, 3, 4, 5, 6, 7, 32'hFFFF_FFFF);
    run_until(1, 60, "t3");
    exp8 = '{1, 2, 3, 4, 5, 6, 7, 32'hFFFF_FFFF};
    check_pair("t3", 0);
    if (fa_q.size() == 8) begin
      check("t3_fb6", fb_q[6], 32'd7);
      check("t3_fa7", fa_q[7], 32'hFFFF_FFFF);
      check("t3_fb7", fb_q[7], 32'hFFFF_FFFF);
    end

    // Back-to-back pairs
    do_reset();
    push8(10, 20, 30, 40, 15, 25, 35, 45);
    push8(100, 101, 102, 103, 1, 2, 3, 4);
    push8(7, 7, 7, 7, 7, 7, 7, 7);
    run_until(3, 150, "t4");
    check("t4_starts", 32'(start_cyc.size()), 32'd3);
    if (start_cyc.size() == 3 && done_cyc.size() == 3) begin
      check("t4_start_gap1", 32'(start_cyc[1] - start_cyc[0]), 32'd9);
      check("t4_start_gap2", 32'(start_cyc[2] - start_cyc[1]), 32'd9);
      check("t4_done_gap", 32'(done_cyc[2] - done_cyc[1]), 32'd9);
    end
    check("t4_ready_low", 32'(ready_low), 32'd3);
    exp8 = '{10, 15, 20, 25, 30, 35, 40, 45};
    check_pair("t4p0", 0);
    exp8 = '{1, 2, 3, 4, 100, 101, 102, 103};
    check_pair("t4p1", 8);
    exp8 = '{7, 7, 7, 7, 7, 7, 7, 7};
    check_pair("t4p2", 16);

    // Reset in the middle of feeding
    do_reset();
    push8(1, 3, 5, 7, 2, 4, 6, 8);
    for (int k = 0; k < 60 && fa_q.size() < 3; k++) tick();
    check("t5_reached_feed", 32'(fa_q.size()), 32'd3);
    rst = 1'b1;
    tick();
    check("t5_feeding", 32'(feeding), 32'd0);
    check("t5_start", 32'(start_merge), 32'd0);
    check("t5_done", 32'(pair_done), 32'd0);
    check("t5_feed_A", feed_A, 32'd0);
    check("t5_feed_B", feed_B, 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    clear_obs();
    for (int k = 0; k < 4; k++) tick();
    check("t5_idle_no_start", 32'(start_cyc.size()), 32'd0);
    check("t5_ready_back", 32'(in_ready), 32'd1);
    push8(9, 11, 13, 15, 10, 12, 14, 16);
    run_until(1, 60, "t5");
    exp8 = '{9, 10, 11, 12, 13, 14, 15, 16};
    check_pair("t5", 0);

    // Random backpressure on the load side
    clear_obs();
    bp = 1'b1;
    push8(2, 4, 4, 9, 1, 4, 8, 20);
    push8(50, 60, 70, 80, 55, 65, 75, 85);
    run_until(2, 400, "t6");
    bp = 1'b0;
    exp8 = '{1, 2, 4, 4, 4, 8, 9, 20};
    check_pair("t6p0", 0);
    exp8 = '{50, 55, 60, 65, 70, 75, 80, 85};
    check_pair("t6p1", 8);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
